input_port_ctrl: RTL and testbench

INPUT_PORT_CTRL -- requirements
Module: input_port_ctrl

---
 rtl/noc_pkg.sv | 58 +++++
 rtl/xy_route.sv | 33 +++
 rtl/input_port_ctrl.sv | 129 ++++++++++++
 tb/tb_input_port_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// ============================================================================
// Module      : noc_pkg
// Description : Shared NoC definitions: flit width, flit types, port encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package noc_pkg;

  localparam int FLIT_W   = 16;
  localparam int NUM_PORT = 5;

  // Flit type field occupies the two MSBs of every flit
  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  localparam int P_LOCAL = 0;
  localparam int P_NORTH = 1;
  localparam int P_EAST  = 2;
  localparam int P_SOUTH = 3;
  localparam int P_WEST  = 4;

  localparam logic [NUM_PORT-1:0] OH_LOCAL = NUM_PORT'(1) << P_LOCAL;
  localparam logic [NUM_PORT-1:0] OH_NORTH = NUM_PORT'(1) << P_NORTH;
  localparam logic [NUM_PORT-1:0] OH_EAST  = NUM_PORT'(1) << P_EAST;
  localparam logic [NUM_PORT-1:0] OH_SOUTH = NUM_PORT'(1) << P_SOUTH;
  localparam logic [NUM_PORT-1:0] OH_WEST  = NUM_PORT'(1) << P_WEST;

  typedef logic [FLIT_W-1:0]   flit_t;
  typedef logic [NUM_PORT-1:0] port_oh_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_HEAD = 3'd1,
    ST_REQ       = 3'd2,
    ST_SEND      = 3'd3,
    ST_FETCH     = 3'd4,
    ST_LOAD      = 3'd5
  } ipc_state_e;

  function automatic logic [1:0] flit_type(input flit_t f);
    return f[FLIT_W-1 -: 2];
  endfunction

  // A single-flit packet is both a head and a tail
  function automatic logic is_head(input flit_t f);
    return (flit_type(f) == FT_HEAD) || (flit_type(f) == FT_SINGLE);
  endfunction

  function automatic logic is_tail(input flit_t f);
    return (flit_type(f) == FT_TAIL) || (flit_type(f) == FT_SINGLE);
  endfunction

endpackage : noc_pkg

`default_nettype wire

// File: rtl/xy_route.sv
// ============================================================================
// Module      : xy_route
// Description : Dimension-ordered (X then Y) route computation, one-hot output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xy_route
  import noc_pkg::*;
(
  input  logic [3:0]          i_dest_x,
  input  logic [3:0]          i_dest_y,
  input  logic [3:0]          i_x_id,
  input  logic [3:0]          i_y_id,
  output logic [NUM_PORT-1:0] o_port
);

  always_comb begin
    o_port = OH_LOCAL;
    if (i_dest_x > i_x_id) begin
      o_port = OH_EAST;
    end else if (i_dest_x < i_x_id) begin
      o_port = OH_WEST;
    end else if (i_dest_y > i_y_id) begin
      o_port = OH_NORTH;
    end else if (i_dest_y < i_y_id) begin
      o_port = OH_SOUTH;
    end
  end

endmodule : xy_route

`default_nettype wire

// File: rtl/input_port_ctrl.sv
// ============================================================================
// Module      : input_port_ctrl
// Description : Router input-port controller: FIFO fetch, XY route, request, send.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_port_ctrl
  import noc_pkg::*;
#(
  parameter logic [3:0] X_ID = 4'd0,
  parameter logic [3:0] Y_ID = 4'd0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_fifo_emp,
  output logic                o_fifo_rd,
  input  logic [FLIT_W-1:0]   i_fifo_data,
  output logic [NUM_PORT-1:0] o_req,
  input  logic                i_gnt,
  output logic [FLIT_W-1:0]   o_flit_out,
  output logic                o_flit_valid,
  input  logic                i_out_ready,
  output logic [7:0]          o_err_cnt
);

  ipc_state_e          r_state;
  flit_t               r_flit;
  port_oh_t            r_req;
  logic                r_flit_valid;
  logic [7:0]          r_err_cnt;

  port_oh_t            w_route;
  logic                w_err_sat;

  xy_route u_xy_route (
    .i_dest_x (i_fifo_data[7:4]),
    .i_dest_y (i_fifo_data[3:0]),
    .i_x_id   (X_ID),
    .i_y_id   (Y_ID),
    .o_port   (w_route)
  );

  assign w_err_sat = (r_err_cnt == 8'hFF);

  // The read strobe is decoded from state so the FIFO pops in the IDLE/FETCH
  // cycle and its data is present during the following LOAD cycle; gating by
  // rst_n keeps it low while reset is held.
  assign o_fifo_rd = rst_n && !i_fifo_emp &&
                     ((r_state == ST_IDLE) || (r_state == ST_FETCH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_flit       <= '0;
      r_req        <= '0;
      r_flit_valid <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (!i_fifo_emp) begin
            r_state <= ST_LOAD_HEAD;
          end
        end

        ST_LOAD_HEAD: begin
          r_flit <= i_fifo_data;
          if (is_head(i_fifo_data)) begin
            r_req   <= w_route;
            r_state <= ST_REQ;
          end else begin
            if (!w_err_sat) begin
              r_err_cnt <= r_err_cnt + 8'd1;
            end
            r_state <= ST_IDLE;
          end
        end

        ST_REQ: begin
          if (i_gnt) begin
            r_flit_valid <= 1'b1;
            r_state      <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (i_out_ready) begin
            r_flit_valid <= 1'b0;
            if (is_tail(r_flit)) begin
              r_req   <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_FETCH;
            end
          end
        end

        ST_FETCH: begin
          if (!i_fifo_emp) begin
            r_state <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          // A stray head inside a packet is flagged but still forwarded
          r_flit       <= i_fifo_data;
          r_flit_valid <= 1'b1;
          r_state      <= ST_SEND;
          if (is_head(i_fifo_data) && !w_err_sat) begin
            r_err_cnt <= r_err_cnt + 8'd1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_req        = r_req;
  assign o_flit_out   = r_flit;
  assign o_flit_valid = r_flit_valid;
  assign o_err_cnt    = r_err_cnt;

endmodule : input_port_ctrl

`default_nettype wire

// File: tb/tb_input_port_ctrl.sv
// ============================================================================
// Module      : tb_input_port_ctrl
// Description : Directed + randomized self-checking bench for input_port_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_input_port_ctrl;

  localparam logic [3:0] X_ID = 4'd1;
  localparam logic [3:0] Y_ID = 4'd1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_fifo_emp = 1'b1;
  logic        o_fifo_rd;
  logic [15:0] i_fifo_data = 16'h0;
  logic [4:0]  o_req;
  logic        i_gnt = 1'b0;
  logic [15:0] o_flit_out;
  logic        o_flit_valid;
  logic        i_out_ready = 1'b0;
  logic [7:0]  o_err_cnt;

  always #5 clk = ~clk;

  input_port_ctrl #(.X_ID(X_ID), .Y_ID(Y_ID)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_fifo_emp   (i_fifo_emp),
    .o_fifo_rd    (o_fifo_rd),
    .i_fifo_data  (i_fifo_data),
    .o_req        (o_req),
    .i_gnt        (i_gnt),
    .o_flit_out   (o_flit_out),
    .o_flit_valid (o_flit_valid),
    .i_out_ready  (i_out_ready),
    .o_err_cnt    (o_err_cnt)
  );

  typedef struct packed {
    logic [15:0] flit;
    logic [4:0]  port;
  } exp_t;

  logic [15:0] fifo_q[$];
  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          exp_err = 0;
  bit          in_pkt = 1'b0;
  logic [4:0]  cur_port = 5'b0;
  bit          rd_seen = 1'b0;
  bit          prev_rd = 1'b0;
  int          n_rd = 0;
  int          n_acc = 0;
  bit          saw_req = 1'b0;
  bit          saw_valid = 1'b0;

  function automatic logic [4:0] route(input logic [15:0] f);
    logic [3:0] dx;
    logic [3:0] dy;
    dx = f[7:4];
    dy = f[3:0];
    if (dx > X_ID) return 5'b00100;
    if (dx < X_ID) return 5'b10000;
    if (dy > Y_ID) return 5'b00010;
    if (dy < Y_ID) return 5'b01000;
    return 5'b00001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Packet-level reference: what the port must forward, on which port, and
  // how many protocol errors it must count, for any stream of flits.
  task automatic push(input logic [15:0] f);
    exp_t e;
    fifo_q.push_back(f);
    i_fifo_emp = 1'b0;
    if (!in_pkt) begin
      if (f[14]) begin
        cur_port = route(f);
        e.flit = f; e.port = cur_port;
        exp_q.push_back(e);
        in_pkt = (f[15:14] == 2'b01);
      end else if (exp_err < 255) begin
        exp_err++;
      end
    end else begin
      e.flit = f; e.port = cur_port;
      exp_q.push_back(e);
      if (f[14] && exp_err < 255) exp_err++;
      if (f[15]) in_pkt = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (o_fifo_rd) begin
      n_rd++;
      chk("rd_while_empty", {31'b0, i_fifo_emp}, 32'd0);
      chk("rd_back_to_back", {31'b0, prev_rd}, 32'd0);
    end
    if (o_req != 5'b0) saw_req = 1'b1;
    if (o_flit_valid) begin
      saw_valid = 1'b1;
      if (exp_q.size() == 0) begin
        chk("unexpected_flit", {31'b0, o_flit_valid}, 32'd0);
      end else begin
        chk("flit_out", {16'b0, o_flit_out}, {16'b0, exp_q[0].flit});
        chk("req_during_send", {27'b0, o_req}, {27'b0, exp_q[0].port});
        if (i_out_ready) begin
          void'(exp_q.pop_front());
          n_acc++;
        end
      end
    end
    rd_seen = o_fifo_rd;
    prev_rd = o_fifo_rd;
    @(posedge clk);
    #1;
    if (rd_seen && fifo_q.size() > 0) i_fifo_data = fifo_q.pop_front();
    else i_fifo_data = 16'($urandom);
    i_fifo_emp = (fifo_q.size() == 0);
  endtask

  task automatic wait_valid(input logic [15:0] f, input int budget);
    int k;
    k = 0;
    while (!(o_flit_valid && o_flit_out == f) && k < budget) begin
      tick();
      k++;
    end
    chk("wait_valid", {15'b0, o_flit_valid, o_flit_out}, {15'b0, 1'b1, f});
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() > 0 || fifo_q.size() > 0 || o_flit_valid) && k < budget) begin
      tick();
      k++;
    end
    tick();
    tick();
    chk("drain_left", exp_q.size(), 32'd0);
  endtask

  function automatic logic [15:0] rand_flit();
    logic [15:0] f;
    f = 16'($urandom);
    f[15:14] = 2'($urandom_range(0, 3));
    return f;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int k;
    int pushed;
    bit started;

    // ---------------- reset state
    rst_n = 1'b0;
    tick();
    tick();
    i_fifo_emp = 1'b0;
    #1;
    chk("rd_in_reset", {31'b0, o_fifo_rd}, 32'd0);
    i_fifo_emp = 1'b1;
    chk("rst_req", {27'b0, o_req}, 32'd0);
    chk("rst_valid", {31'b0, o_flit_valid}, 32'd0);
    chk("rst_flit", {16'b0, o_flit_out}, 32'd0);
    chk("rst_err", {24'b0, o_err_cnt}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // ---------------- single-flit packet, late grant
    i_gnt = 1'b0; i_out_ready = 1'b0;
    push(16'hC021);
    k = 0;
    while (o_req == 5'b0 && k < 20) begin tick(); k++; end
    chk("t1_req", {27'b0, o_req}, {27'b0, 5'b00100});
    chk("t1_no_valid_before_gnt", {31'b0, o_flit_valid}, 32'd0);
    tick();
    tick();
    chk("t1_req_held", {27'b0, o_req}, {27'b0, 5'b00100});
    i_gnt = 1'b1;
    tick();
    i_gnt = 1'b0;
    chk("t1_valid", {31'b0, o_flit_valid}, 32'd1);
    chk("t1_flit", {16'b0, o_flit_out}, 32'hC021);
    tick();
    chk("t1_flit_hold", {16'b0, o_flit_out}, 32'hC021);
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;
    chk("t1_req_drop", {27'b0, o_req}, 32'd0);
    chk("t1_valid_drop", {31'b0, o_flit_valid}, 32'd0);

    // ---------------- three-flit packet to LOCAL
    i_gnt = 1'b1; i_out_ready = 1'b1;
    base = n_acc;
    started = 1'b0;
    push(16'h4011); push(16'h0127); push(16'h8098);
    k = 0;
    while (n_acc - base < 3 && k < 40) begin
      tick();
      k++;
      if (o_req != 5'b0) started = 1'b1;
      if (started && n_acc - base < 3) chk("t2_req_held", {27'b0, o_req}, 32'd1);
    end
    chk("t2_accepted", n_acc - base, 32'd3);
    chk("t2_req_drop", {27'b0, o_req}, 32'd0);

    // ---------------- stray body flit while idle
    i_gnt = 1'b0; i_out_ready = 1'b0;
    base = n_rd; saw_req = 1'b0; saw_valid = 1'b0;
    push(16'h0032);
    repeat (6) tick();
    chk("t3_rd_count", n_rd - base, 32'd1);
    chk("t3_no_req", {31'b0, saw_req}, 32'd0);
    chk("t3_no_valid", {31'b0, saw_valid}, 32'd0);
    chk("t3_err", {24'b0, o_err_cnt}, exp_err);

    // ---------------- body held in SEND by back-pressure
    i_gnt = 1'b1; i_out_ready = 1'b1;
    push(16'h4011); push(16'h0127); push(16'h8098);
    wait_valid(16'h0127, 30);
    i_out_ready = 1'b0;
    repeat (5) begin
      tick();
      chk("t4_hold_flit", {16'b0, o_flit_out}, 32'h0127);
      chk("t4_hold_valid", {31'b0, o_flit_valid}, 32'd1);
      chk("t4_no_rd", {31'b0, o_fifo_rd}, 32'd0);
    end
    i_out_ready = 1'b1;
    drain(40);
    chk("t4_req_drop", {27'b0, o_req}, 32'd0);

    // ---------------- FIFO starves after the head
    i_gnt = 1'b1; i_out_ready = 1'b1;
    push(16'h4022);
    wait_valid(16'h4022, 20);
    tick();
    repeat (4) begin
      chk("t5_req_held", {27'b0, o_req}, {27'b0, 5'b00100});
      chk("t5_no_valid", {31'b0, o_flit_valid}, 32'd0);
      chk("t5_no_rd", {31'b0, o_fifo_rd}, 32'd0);
      tick();
    end
    base = n_rd;
    push(16'h8055);
    wait_valid(16'h8055, 10);
    chk("t5_rd_once", n_rd - base, 32'd1);
    drain(20);
    chk("t5_req_drop", {27'b0, o_req}, 32'd0);

    // ---------------- asynchronous reset mid-packet
    i_gnt = 1'b1; i_out_ready = 1'b0;
    push(16'h4011); push(16'h0127);
    wait_valid(16'h4011, 20);
    chk("t6_err_before", {24'b0, o_err_cnt}, exp_err);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_req", {27'b0, o_req}, 32'd0);
    chk("t6_valid", {31'b0, o_flit_valid}, 32'd0);
    chk("t6_flit", {16'b0, o_flit_out}, 32'd0);
    chk("t6_err", {24'b0, o_err_cnt}, 32'd0);
    fifo_q.delete(); exp_q.delete();
    in_pkt = 1'b0; exp_err = 0; i_fifo_emp = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    i_out_ready = 1'b1;
    push(16'hC021);
    wait_valid(16'hC021, 20);
    drain(20);
    chk("t6_restart_req", {27'b0, o_req}, 32'd0);

    // ---------------- randomized traffic against the packet model
    pushed = 0;
    for (int c = 0; c < 3000 && (pushed < 120 || exp_q.size() > 0 || fifo_q.size() > 0); c++) begin
      i_gnt = ($urandom_range(0, 2) != 0);
      i_out_ready = ($urandom_range(0, 3) != 0);
      if (pushed < 120 && fifo_q.size() < 4 && $urandom_range(0, 1) == 1) begin
        push(rand_flit());
        pushed++;
        if (pushed == 120 && in_pkt) push(16'h8000);
      end
      tick();
    end
    i_gnt = 1'b1; i_out_ready = 1'b1;
    drain(200);
    chk("rand_err", {24'b0, o_err_cnt}, exp_err);
    chk("rand_req_idle", {27'b0, o_req}, 32'd0);

    // ---------------- error counter saturation
    for (int i = 0; i < 260; i++) push(16'h0032 ^ 16'(i));
    drain(700);
    chk("sat_err", {24'b0, o_err_cnt}, exp_err);
    chk("sat_err_ff", {24'b0, o_err_cnt}, 32'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_input_port_ctrl

`default_nettype wire
